// File: rtl/tour_cmd_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// tour_cmd_sequencer_pkg
//   Shared definitions for the Knight command replay engine:
//   - POS_ACK_DEF : default positive acknowledge byte returned by the Knight
//   - CAL_OPCODE  : opcode (cmd[15:12]) of a calibrate command
//   - TIMER_W     : width of the per-command response timer
//   - state_t     : replay FSM states
//   - is_cal_cmd  : true when a command word carries the calibrate opcode
// ---------------------------------------------------------------------------
package tour_cmd_sequencer_pkg;

  localparam logic [7:0]  POS_ACK_DEF = 8'hA5;
  localparam logic [3:0]  CAL_OPCODE  = 4'h0;
  localparam int unsigned TIMER_W     = 26;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SNT,
    WAIT_RESP,
    CHECK,
    FINISH
  } state_t;

  function automatic logic is_cal_cmd(input logic [15:0] c);
    return c[15:12] == CAL_OPCODE;
  endfunction

endpackage

// File: rtl/tour_cmd_sequencer_cmd_buf.sv
// ---------------------------------------------------------------------------
// tour_cmd_sequencer_cmd_buf
//   DEPTH x 16 command store with one write port (append at the tail) and
//   one combinational read port, plus fill count and sticky overflow flag.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     wr_en     : append wr_data (dropped and ovf set when full)
//     wr_data   : command word to append
//     clr       : empty the buffer and clear ovf (wins over wr_en)
//     rd_idx    : read address
//     rd_data   : entry at rd_idx
//     count     : number of stored entries (0..DEPTH)
//     ovf       : sticky, a write was attempted while full
//   The caller is responsible for gating wr_en/clr to the idle state.
// ---------------------------------------------------------------------------
module tour_cmd_sequencer_cmd_buf
  import tour_cmd_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [15:0]                wr_data,
  input  logic                       clr,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [15:0]                rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full;

  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (wr_en) begin
      if (full) ovf_d = 1'b1;
      else      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !clr && !full) mem_q[count_q[IW-1:0]] <= wr_data;
  end

  assign rd_data = mem_q[rd_idx];
  assign count   = count_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/tour_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tour_cmd_sequencer
//   Replays a stored script of 16-bit Knight commands through RemoteComm.
//   Each command is strobed out, then the engine waits for cmd_snt and a
//   response byte, checks it against POS_ACK and enforces a per-command
//   timeout (shorter for calibrate commands). STOP_ON_ERR selects whether
//   the first error ends the replay or is only counted.
//   Ports:
//     clk, rst              : clock, asynchronous active-high reset
//     wr_en, wr_cmd         : append a command (idle only)
//     clr                   : empty the script (idle only, beats start/wr_en)
//     start                 : replay from entry 0 (idle only, beats wr_en)
//     abort                 : end a running replay with pass=0
//     cmd, snd_cmd          : command word and one-cycle send strobe
//     cmd_snt               : RemoteComm finished sending cmd
//     resp_rdy, resp        : response byte strobe and value
//     busy                  : replay in progress
//     done                  : one-cycle pulse when a replay ends
//     pass                  : sticky result of the last replay
//     err_cnt               : errors seen in the last replay (saturating)
//     cmd_idx               : current / last issued entry
//     count                 : entries stored
//     ovf                   : sticky, write attempted while full
// ---------------------------------------------------------------------------
module tour_cmd_sequencer
  import tour_cmd_sequencer_pkg::*;
#(
  parameter int unsigned          DEPTH        = 16,
  parameter logic [TIMER_W-1:0]   TIMEOUT_CLKS = 26'd40_000_000,
  parameter logic [TIMER_W-1:0]   CAL_TIMEOUT  = 26'd1_000_000,
  parameter logic                 STOP_ON_ERR  = 1'b1,
  parameter logic [7:0]           POS_ACK      = POS_ACK_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [15:0]                wr_cmd,
  input  logic                       clr,
  input  logic                       start,
  input  logic                       abort,
  output logic [15:0]                cmd,
  output logic                       snd_cmd,
  input  logic                       cmd_snt,
  input  logic                       resp_rdy,
  input  logic [7:0]                 resp,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH+1)-1:0] err_cnt,
  output logic [$clog2(DEPTH)-1:0]   cmd_idx,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  state_t               state_q;
  logic [15:0]          cmd_q;
  logic                 snd_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic                 aborted_q;
  logic                 timeout_q;
  logic                 resp_vld_q;
  logic [7:0]           resp_q;
  logic [CW-1:0]        err_q;
  logic [IW-1:0]        idx_q;
  logic [TIMER_W-1:0]   timer_q;

  logic [15:0]          buf_rd;
  logic [CW-1:0]        buf_count;
  logic                 buf_ovf;
  logic                 buf_wr;
  logic                 buf_clr;
  logic                 idle;
  logic                 in_replay;
  logic                 resp_err;
  logic                 last_entry;
  logic                 expired;

  assign idle       = (state_q == IDLE);
  assign buf_clr    = idle && clr;
  assign buf_wr     = idle && wr_en && !clr && !start;
  assign in_replay  = state_q inside {SEND, WAIT_SNT, WAIT_RESP, CHECK};
  assign resp_err   = timeout_q || (resp_q != POS_ACK);
  assign last_entry = (CW'(idx_q) == (buf_count - CW'(1)));
  assign expired    = (timer_q == '0);

  tour_cmd_sequencer_cmd_buf #(
    .DEPTH (DEPTH)
  ) u_cmd_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_data (wr_cmd),
    .clr     (buf_clr),
    .rd_idx  (idx_q),
    .rd_data (buf_rd),
    .count   (buf_count),
    .ovf     (buf_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      snd_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      aborted_q  <= 1'b0;
      timeout_q  <= 1'b0;
      resp_vld_q <= 1'b0;
      resp_q     <= '0;
      err_q      <= '0;
      idx_q      <= '0;
      timer_q    <= '0;
    end else begin
      snd_q  <= 1'b0;
      done_q <= 1'b0;
      // Abort pre-empts every replay state, including a response arriving
      // in the same cycle, and suppresses any pending send strobe.
      if (abort && in_replay) begin
        aborted_q <= 1'b1;
        state_q   <= FINISH;
      end else begin
        case (state_q)
          IDLE: begin
            if (start && !clr) begin
              err_q     <= '0;
              idx_q     <= '0;
              aborted_q <= 1'b0;
              if (buf_count == '0) begin
                state_q <= FINISH;
              end else begin
                busy_q  <= 1'b1;
                state_q <= SEND;
              end
            end
          end
          SEND: begin
            cmd_q      <= buf_rd;
            snd_q      <= 1'b1;
            timer_q    <= is_cal_cmd(buf_rd) ? CAL_TIMEOUT : TIMEOUT_CLKS;
            resp_vld_q <= 1'b0;
            timeout_q  <= 1'b0;
            state_q    <= WAIT_SNT;
          end
          WAIT_SNT: begin
            // An early response is held so WAIT_RESP can consume it.
            if (resp_rdy && !resp_vld_q) begin
              resp_q     <= resp;
              resp_vld_q <= 1'b1;
            end
            if (expired) begin
              if (!resp_vld_q && !resp_rdy) timeout_q <= 1'b1;
              state_q <= CHECK;
            end else begin
              timer_q <= timer_q - TIMER_W'(1);
              if (cmd_snt) state_q <= WAIT_RESP;
            end
          end
          WAIT_RESP: begin
            if (resp_vld_q) begin
              state_q <= CHECK;
            end else if (resp_rdy) begin
              resp_q  <= resp;
              state_q <= CHECK;
            end else if (expired) begin
              timeout_q <= 1'b1;
              state_q   <= CHECK;
            end else begin
              timer_q <= timer_q - TIMER_W'(1);
            end
          end
          CHECK: begin
            if (resp_err && (err_q != '1)) err_q <= err_q + CW'(1);
            if ((resp_err && STOP_ON_ERR) || last_entry) begin
              state_q <= FINISH;
            end else begin
              idx_q   <= idx_q + IW'(1);
              state_q <= SEND;
            end
          end
          FINISH: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (err_q == '0) && !aborted_q;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cmd     = cmd_q;
  assign snd_cmd = snd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign cmd_idx = idx_q;
  assign count   = buf_count;
  assign ovf     = buf_ovf;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
module tb_tour_cmd_sequencer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TO    = 100;
  localparam int unsigned CALTO = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, clr, start, abort;
  logic [15:0] wr_cmd;
  logic        cmd_snt, resp_rdy;
  logic [7:0]  resp;
  logic        sel;

  logic [15:0] a_cmd, b_cmd;
  logic        a_snd, b_snd, a_busy, b_busy, a_done, b_done, a_pass, b_pass, a_ovf, b_ovf;
  logic [4:0]  a_err, b_err, a_count, b_count;
  logic [3:0]  a_idx, b_idx;

  // A halts on first error, B logs and continues.
  tour_cmd_sequencer #(
    .DEPTH(DEPTH), .TIMEOUT_CLKS(26'd100), .CAL_TIMEOUT(26'd50), .STOP_ON_ERR(1'b1), .POS_ACK(8'hA5)
  ) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .clr(clr), .start(start), .abort(abort),
    .cmd(a_cmd), .snd_cmd(a_snd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_cnt(a_err), .cmd_idx(a_idx),
    .count(a_count), .ovf(a_ovf)
  );

  tour_cmd_sequencer #(
    .DEPTH(DEPTH), .TIMEOUT_CLKS(26'd100), .CAL_TIMEOUT(26'd50), .STOP_ON_ERR(1'b0), .POS_ACK(8'hA5)
  ) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_cmd(wr_cmd), .clr(clr), .start(start), .abort(abort),
    .cmd(b_cmd), .snd_cmd(b_snd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_cnt(b_err), .cmd_idx(b_idx),
    .count(b_count), .ovf(b_ovf)
  );

  logic [15:0] cmd_s;
  logic        snd_s, busy_s, done_s, pass_s, ovf_s;
  logic [4:0]  err_s, count_s;
  logic [3:0]  idx_s;
  assign cmd_s   = sel ? b_cmd   : a_cmd;
  assign snd_s   = sel ? b_snd   : a_snd;
  assign busy_s  = sel ? b_busy  : a_busy;
  assign done_s  = sel ? b_done  : a_done;
  assign pass_s  = sel ? b_pass  : a_pass;
  assign ovf_s   = sel ? b_ovf   : a_ovf;
  assign err_s   = sel ? b_err   : a_err;
  assign count_s = sel ? b_count : a_count;
  assign idx_s   = sel ? b_idx   : a_idx;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RemoteComm / Knight model: cmd_snt 3 cycles after the strobe, then the
  // scripted response byte 3 cycles later (bit 8 clear = never answered).
  logic [8:0]  script   [16];
  int          snd_cyc  [16];
  logic [15:0] snd_cmdv [16];
  int          n_snd = 0;
  int          rt = 0;
  int          rcur = 0;
  logic        ractive = 1'b0;

  always @(negedge clk) begin
    cmd_snt  = 1'b0;
    resp_rdy = 1'b0;
    if (rst) begin
      n_snd   = 0;
      ractive = 1'b0;
      resp    = 8'h00;
    end else begin
      if (ractive) begin
        rt++;
        if (rt == 3) cmd_snt = 1'b1;
        if (rt == 6) begin
          ractive = 1'b0;
          if (rcur < 16 && script[rcur][8]) begin
            resp_rdy = 1'b1;
            resp     = script[rcur][7:0];
          end
        end
      end
      if (snd_s) begin
        rcur = n_snd;
        if (n_snd < 16) begin
          snd_cyc[n_snd]  = cyc;
          snd_cmdv[n_snd] = cmd_s;
        end
        n_snd++;
        ractive = 1'b1;
        rt      = 0;
      end
    end
  end

  typedef struct {
    logic        wr, cl, st;
    logic [15:0] data;
    int unsigned cnt;
    logic        ovf, busy, done, pass;
  } vec_t;

  vec_t vt [24];

  function automatic vec_t mk(input logic w, input logic c, input logic s, input logic [15:0] d,
                              input int unsigned n, input logic o, input logic b,
                              input logic dn, input logic p);
    vec_t v;
    v.wr = w; v.cl = c; v.st = s; v.data = d; v.cnt = n;
    v.ovf = o; v.busy = b; v.done = dn; v.pass = p;
    return v;
  endfunction

  task automatic clear_script();
    for (int i = 0; i < 16; i++) script[i] = 9'h000;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; clr = 1'b0; start = 1'b0; abort = 1'b0; wr_cmd = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v);
    wr_en = 1'b1; wr_cmd = v;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (done_s !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, done_s, 1);
  endtask

  task automatic wait_snd(input string name, input int max);
    int n = 0;
    while (snd_s !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, snd_s, 1);
  endtask

  initial begin
    sel = 1'b0;
    clear_script();
    rst = 1'b1; wr_en = 1'b0; clr = 1'b0; start = 1'b0; abort = 1'b0; wr_cmd = 16'h0000;

    for (int unsigned i = 0; i < 17; i++)
      vt[i] = mk(1, 0, 0, 16'h4100 + 16'(i), (i < 16) ? i + 1 : 16, i == 16, 0, 0, 0);
    vt[17] = mk(1, 1, 0, 16'h4200, 0, 0, 0, 0, 0);  // clr beats wr_en
    vt[18] = mk(1, 0, 1, 16'h4201, 0, 0, 0, 0, 0);  // start (empty) beats wr_en
    vt[19] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 1, 1);  // done pulse, pass
    vt[20] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);  // pulse is single, pass sticky
    vt[21] = mk(1, 0, 0, 16'h4202, 1, 0, 0, 0, 1);
    vt[22] = mk(0, 1, 1, 16'h0000, 0, 0, 0, 0, 1);  // clr beats start
    vt[23] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 0, 1);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd", cmd_s, 16'h0000);
    check("rst_snd", snd_s, 0);
    check("rst_busy", busy_s, 0);
    check("rst_done", done_s, 0);
    check("rst_pass", pass_s, 0);
    check("rst_err", err_s, 0);
    check("rst_idx", idx_s, 0);
    check("rst_count", count_s, 0);
    check("rst_ovf", ovf_s, 0);
    rst = 1'b0;
    @(negedge clk);

    // Buffer fill / overflow / priority table
    for (int i = 0; i < 24; i++) begin
      wr_en = vt[i].wr; clr = vt[i].cl; start = vt[i].st; wr_cmd = vt[i].data;
      @(negedge clk);
      wr_en = 1'b0; clr = 1'b0; start = 1'b0;
      check($sformatf("tbl%0d_count", i), count_s, vt[i].cnt);
      check($sformatf("tbl%0d_ovf", i), ovf_s, vt[i].ovf);
      check($sformatf("tbl%0d_busy", i), busy_s, vt[i].busy);
      check($sformatf("tbl%0d_done", i), done_s, vt[i].done);
      check($sformatf("tbl%0d_pass", i), pass_s, vt[i].pass);
    end

    // Two commands, both acknowledged
    sel = 1'b0;
    do_reset();
    clear_script();
    script[0] = {1'b1, 8'hA5};
    script[1] = {1'b1, 8'hA5};
    push(16'h0000);
    push(16'h4001);
    go();
    check("t1_busy", busy_s, 1);
    wait_done("t1_done", 400);
    check("t1_nsnd", n_snd, 2);
    check("t1_cmd0", snd_cmdv[0], 16'h0000);
    check("t1_cmd1", snd_cmdv[1], 16'h4001);
    check("t1_cmd_hold", cmd_s, 16'h4001);
    check("t1_pass", pass_s, 1);
    check("t1_err", err_s, 0);
    check("t1_idx", idx_s, 1);
    check("t1_busy_end", busy_s, 0);

    // Stop on first bad response
    do_reset();
    clear_script();
    script[0] = {1'b1, 8'hA5};
    script[1] = {1'b1, 8'h5A};
    script[2] = {1'b1, 8'hA5};
    push(16'h4001);
    push(16'h4002);
    push(16'h4003);
    go();
    wait_done("t2_done", 400);
    check("t2_pass", pass_s, 0);
    check("t2_err", err_s, 1);
    check("t2_idx", idx_s, 1);
    repeat (20) @(negedge clk);
    check("t2_nsnd", n_snd, 2);

    // Continue past a timeout
    sel = 1'b1;
    do_reset();
    clear_script();
    script[0] = {1'b1, 8'hA5};
    script[2] = {1'b1, 8'hA5};
    push(16'h4011);
    push(16'h4012);
    push(16'h4013);
    go();
    wait_done("t3_done", 800);
    check("t3_nsnd", n_snd, 3);
    check("t3_err", err_s, 1);
    check("t3_pass", pass_s, 0);
    check("t3_idx", idx_s, 2);
    check("t3_gap_ack", snd_cyc[1] - snd_cyc[0], 9);
    check("t3_gap_timeout", snd_cyc[2] - snd_cyc[1], TO + 3);
    check("t3_cmd2", snd_cmdv[2], 16'h4013);

    // Calibrate command uses the shorter timeout
    do_reset();
    clear_script();
    script[1] = {1'b1, 8'hA5};
    push(16'h0123);
    push(16'h4000);
    go();
    wait_done("t3c_done", 800);
    check("t3c_nsnd", n_snd, 2);
    check("t3c_gap", snd_cyc[1] - snd_cyc[0], CALTO + 3);
    check("t3c_err", err_s, 1);

    // Abort in WAIT_RESP, then replay again
    sel = 1'b0;
    do_reset();
    clear_script();
    script[1] = {1'b1, 8'hA5};
    script[2] = {1'b1, 8'hA5};
    push(16'h4001);
    push(16'h4002);
    go();
    wait_snd("t5_snd0", 20);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    begin
      int n = 0;
      while (done_s !== 1'b1 && n < 2) begin
        @(negedge clk);
        n++;
      end
    end
    check("t5_done_2clk", done_s, 1);
    check("t5_pass", pass_s, 0);
    check("t5_count", count_s, 2);
    repeat (20) @(negedge clk);
    check("t5_nsnd", n_snd, 1);
    go();
    wait_done("t5_redone", 400);
    check("t5_re_nsnd", n_snd, 3);
    check("t5_re_cmd", snd_cmdv[1], 16'h4001);
    check("t5_re_pass", pass_s, 1);
    check("t5_re_err", err_s, 0);

    // Reset during WAIT_SNT
    do_reset();
    clear_script();
    push(16'h4001);
    go();
    wait_snd("t6_snd", 20);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", busy_s, 0);
    check("t6_snd0", snd_s, 0);
    check("t6_count", count_s, 0);
    check("t6_cmd", cmd_s, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle_busy", busy_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
